// File: rtl/serial_subtractor16.sv
// Bit-serial a - b - bin, LSB first; done pulses WIDTH+1 cycles after an accepted start.
// No backpressure: start is only sampled in IDLE/DONE and is ignored while busy.
module serial_subtractor16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic a_bit, b_bit, d_bit, br_nxt;

    // One full-subtractor cell; the operand LSBs are the bits of the current position.
    always_comb begin
        a_bit  = a_sh_q[0];
        b_bit  = b_sh_q[0];
        d_bit  = a_bit ^ b_bit ^ br_q;
        br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                br_d   = br_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // On the last bit the shift-register LSBs hold the operand sign bits.
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_nxt;
                    ovf_d   = (a_bit ^ b_bit) & (a_bit ^ d_bit);
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor16.sv
// Directed-vector bench for serial_subtractor16 (WIDTH=16) with multi-cycle corner sequences.
module tb_serial_subtractor16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        bin;
    logic        busy, done, bout, ovf;
    logic [15:0] diff;

    int checks = 0;
    int errors = 0;

    serial_subtractor16 #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request and waits (bounded) for done; inj >= 0 drives a spurious
    // start with different operands on that RUN cycle index.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                          input int inj, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; bin = ibin;
        @(negedge clk);
        start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (busy) bcnt++;
            if (lat == inj) begin
                start = 1'b1; a = 16'd1; b = 16'd1; bin = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, bcnt, ndone, last_t, nres;
        logic [16:0] full;
        int s;

        vecs[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1]  = '{16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[2]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[8]  = '{16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[9]  = '{16'h7FFF, 16'h0000, 1'b1, 16'h7FFE, 1'b0, 1'b0};
        vecs[10] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        vecs[11] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, -1, lat, bcnt);
            chk($sformatf("v%0d_lat", i),  32'(lat),  32'd16);
            chk($sformatf("v%0d_busy", i), 32'(bcnt), 32'd16);
            chk($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].diff));
            chk($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
            chk($sformatf("v%0d_ovf", i),  32'(ovf),  32'(vecs[i].ovf));
        end

        // done is a single-cycle pulse when no new start follows.
        @(negedge clk);
        chk("done_drop", 32'(done), 32'd0);
        chk("diff_hold", 32'(diff), 32'h4B4B);

        // Spurious start during RUN is ignored.
        run_op(16'd9, 16'd4, 1'b0, 4, lat, bcnt);
        chk("ign_lat",  32'(lat),  32'd16);
        chk("ign_busy", 32'(bcnt), 32'd16);
        chk("ign_diff", 32'(diff), 32'h0005);
        chk("ign_bout", 32'(bout), 32'd0);

        // start held high: done every 17 cycles, done never lasts two cycles.
        @(negedge clk);
        start = 1'b1; a = 16'd7; b = 16'd2; bin = 1'b0;
        ndone = 0; last_t = 0;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk($sformatf("hold_diff%0d", ndone), 32'(diff), 32'h0005);
                if (ndone > 1) chk($sformatf("hold_period%0d", ndone), 32'(t - last_t), 32'd17);
                last_t = t;
                @(negedge clk);
                t++;
                chk($sformatf("hold_pulse%0d", ndone), 32'({done, busy}), 32'b01);
            end
        end
        chk("hold_count", 32'(ndone), 32'd3);
        start = 1'b0;
        s = 0;
        while (busy && s < 40) begin
            @(negedge clk);
            s++;
        end
        chk("hold_drain", 32'(busy), 32'd0);

        // Reset mid-RUN abandons the operation.
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h0001; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_diff", 32'(diff), 32'd0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("mrst_quiet", 32'(ndone), 32'd0);
        run_op(16'h0100, 16'h0001, 1'b1, -1, lat, bcnt);
        chk("mrst_lat",  32'(lat),  32'd16);
        chk("mrst_diff2", 32'(diff), 32'h00FE);

        // Random vectors against a plain arithmetic model.
        nres = 0;
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            logic        rbin;
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            s    = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
            run_op(ra, rb, rbin, -1, lat, bcnt);
            chk($sformatf("r%0d_lat", i),  32'(lat),  32'd16);
            chk($sformatf("r%0d_diff", i), 32'(diff), 32'(full[15:0]));
            chk($sformatf("r%0d_bout", i), 32'(bout), 32'(full[16]));
            chk($sformatf("r%0d_ovf", i),  32'(ovf),  32'((s > 32767 || s < -32768) ? 1 : 0));
            nres++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
